matrix_entry_ctrl: RTL and testbench

- Controller for the 8x8 matrix input register file and the determinant engine handshake.
- Owns the cursor that addresses the 64x4-bit matrix store, and issues its write strobes for user entry and bulk clear.
- Enforces that every active cell is entered before the solver starts, pulses the solver start, and holds the result phase until acknowledged.
- Sits between the debounced button pulses / switch fields at top level and the matrix store plus determinant state machine.

---
 rtl/matrix_entry_ctrl_pkg.sv | 28 ++
 rtl/matrix_cursor.sv | 56 +++++
 rtl/matrix_entry_ctrl.sv | 161 ++++++++++++++++
 tb/tb_matrix_entry_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_entry_ctrl_pkg.sv
// Shared sizes, FSM state encoding and addressing helpers for the matrix entry controller.
package matrix_entry_ctrl_pkg;

  localparam int W     = 4;
  localparam int NMAX  = 8;
  localparam int AW    = 6;
  localparam int CELLS = NMAX * NMAX;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_ENTER = 3'd2,
    ST_SOLVE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  function automatic logic [AW-1:0] cell_addr(input logic [2:0] row, input logic [2:0] col);
    return AW'(row) * AW'(NMAX) + AW'(col);
  endfunction

  // Number of cells in the active (dim+1) x (dim+1) window.
  function automatic logic [6:0] cells_for_dim(input logic [2:0] dim);
    logic [6:0] n;
    n = 7'(dim) + 7'd1;
    return n * n;
  endfunction

endpackage

// File: rtl/matrix_cursor.sv
// Row/column cursor over the active window: wraps at dim, range-checked jump, store address.
module matrix_cursor
  import matrix_entry_ctrl_pkg::*;
(
  input  logic          clk_i,
  input  logic          srst_i,
  input  logic          clr_i,
  input  logic          adv_i,
  input  logic          jump_i,
  input  logic [2:0]    dim_i,
  input  logic [2:0]    row_sel_i,
  input  logic [2:0]    col_sel_i,
  output logic [2:0]    row_o,
  output logic [2:0]    col_o,
  output logic [AW-1:0] addr_o
);

  logic [2:0] row_q, row_d;
  logic [2:0] col_q, col_d;
  logic       jump_ok;

  always_comb begin
    jump_ok = (row_sel_i <= dim_i) && (col_sel_i <= dim_i);
    row_d   = row_q;
    col_d   = col_q;
    if (clr_i) begin
      row_d = '0;
      col_d = '0;
    end else if (adv_i) begin
      if (col_q == dim_i) begin
        col_d = '0;
        row_d = (row_q == dim_i) ? 3'd0 : row_q + 3'd1;
      end else begin
        col_d = col_q + 3'd1;
      end
    end else if (jump_i && jump_ok) begin
      row_d = row_sel_i;
      col_d = col_sel_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row_o  = row_q;
  assign col_o  = col_q;
  assign addr_o = cell_addr(row_q, col_q);

endmodule

// File: rtl/matrix_entry_ctrl.sv
// Entry controller: clears the matrix store, tracks which active cells were written,
// gates the solver start on completeness and holds DONE until acknowledged.
module matrix_entry_ctrl
  import matrix_entry_ctrl_pkg::*;
(
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          start_i,
  input  logic          ack_i,
  input  logic          enter_i,
  input  logic          jump_i,
  input  logic          clear_i,
  input  logic [2:0]    dim_i,
  input  logic [2:0]    row_sel_i,
  input  logic [2:0]    col_sel_i,
  input  logic [W-1:0]  data_in_i,
  input  logic          solve_done_i,
  output logic          wr_en_o,
  output logic [AW-1:0] wr_addr_o,
  output logic [W-1:0]  wr_data_o,
  output logic [2:0]    cur_row_o,
  output logic [2:0]    cur_col_o,
  output logic [6:0]    entered_cnt_o,
  output logic          incomplete_o,
  output logic          solve_start_o,
  output logic          q_idle_o,
  output logic          q_clear_o,
  output logic          q_enter_o,
  output logic          q_solve_o,
  output logic          q_done_o
);

  state_e           state_q, state_d;
  logic [4:0]       onehot_q, onehot_d;
  logic             wr_en_q, wr_en_d;
  logic [AW-1:0]    wr_addr_q, wr_addr_d;
  logic [W-1:0]     wr_data_q, wr_data_d;
  logic [2:0]       dim_q, dim_d;
  logic [CELLS-1:0] entered_q, entered_d;
  logic [6:0]       cnt_q, cnt_d;
  logic             inc_q, inc_d;
  logic             ss_q, ss_d;

  logic          in_enter, go_clear, enter_start, do_write, do_jump, complete, sweep_last;
  logic [AW-1:0] cur_addr;

  // Event decode; inside ENTER the priority is Clear, then Start, then Enter, then Jump.
  always_comb begin
    in_enter    = (state_q == ST_ENTER);
    go_clear    = ((state_q == ST_IDLE) && start_i) || (in_enter && clear_i);
    enter_start = in_enter && !clear_i && start_i;
    do_write    = in_enter && !clear_i && !start_i && enter_i;
    do_jump     = in_enter && !clear_i && !start_i && !enter_i && jump_i;
    complete    = (cnt_q == cells_for_dim(dim_q));
    sweep_last  = (wr_addr_q == AW'(CELLS - 1));
  end

  matrix_cursor u_cursor (
    .clk_i     (clk_i),
    .srst_i    (reset_i),
    .clr_i     (go_clear),
    .adv_i     (do_write),
    .jump_i    (do_jump),
    .dim_i     (dim_q),
    .row_sel_i (row_sel_i),
    .col_sel_i (col_sel_i),
    .row_o     (cur_row_o),
    .col_o     (cur_col_o),
    .addr_o    (cur_addr)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= ST_IDLE;
      onehot_q <= 5'b10000;
    end else begin
      state_q  <= state_d;
      onehot_q <= onehot_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_i) state_d = ST_CLEAR;
      ST_CLEAR: if (sweep_last) state_d = ST_ENTER;
      ST_ENTER: begin
        if (clear_i)                    state_d = ST_CLEAR;
        else if (start_i && complete)   state_d = ST_SOLVE;
      end
      ST_SOLVE: if (solve_done_i) state_d = ST_DONE;
      ST_DONE:  if (ack_i) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // wr_addr doubles as the sweep counter while in CLEAR.
  always_comb begin
    onehot_d  = {state_d == ST_IDLE, state_d == ST_CLEAR, state_d == ST_ENTER,
                 state_d == ST_SOLVE, state_d == ST_DONE};
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = '0;
    dim_d     = ((state_q == ST_IDLE) && start_i) ? dim_i : dim_q;
    entered_d = entered_q;
    cnt_d     = cnt_q;
    inc_d     = inc_q;
    ss_d      = enter_start && complete;
    if (go_clear) begin
      wr_en_d   = 1'b1;
      wr_addr_d = '0;
      entered_d = '0;
      cnt_d     = '0;
      inc_d     = 1'b0;
    end else if ((state_q == ST_CLEAR) && !sweep_last) begin
      wr_en_d   = 1'b1;
      wr_addr_d = wr_addr_q + AW'(1);
    end else if (do_write) begin
      wr_en_d             = 1'b1;
      wr_addr_d           = cur_addr;
      wr_data_d           = data_in_i;
      entered_d[cur_addr] = 1'b1;
      inc_d               = 1'b0;
      if (!entered_q[cur_addr] && (cnt_q != 7'(CELLS)))
        cnt_d = cnt_q + 7'd1;
    end else if (enter_start) begin
      inc_d = !complete;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      dim_q     <= 3'd7;
      entered_q <= '0;
      cnt_q     <= '0;
      inc_q     <= 1'b0;
      ss_q      <= 1'b0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      dim_q     <= dim_d;
      entered_q <= entered_d;
      cnt_q     <= cnt_d;
      inc_q     <= inc_d;
      ss_q      <= ss_d;
    end
  end

  assign wr_en_o       = wr_en_q;
  assign wr_addr_o     = wr_addr_q;
  assign wr_data_o     = wr_data_q;
  assign entered_cnt_o = cnt_q;
  assign incomplete_o  = inc_q;
  assign solve_start_o = ss_q;
  assign {q_idle_o, q_clear_o, q_enter_o, q_solve_o, q_done_o} = onehot_q;

endmodule

// File: tb/tb_matrix_entry_ctrl.sv
// Self-checking bench: directed scenarios plus randomized traffic against a behavioural model.
module tb_matrix_entry_ctrl;

  localparam int S_IDLE = 0, S_CLEAR = 1, S_ENTER = 2, S_SOLVE = 3, S_DONE = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0, ack = 1'b0, enter = 1'b0, jump = 1'b0, clear = 1'b0, solve_done = 1'b0;
  logic [2:0] dim = '0, row_sel = '0, col_sel = '0;
  logic [3:0] data_in = '0;
  logic       wr_en_o;
  logic [5:0] wr_addr_o;
  logic [3:0] wr_data_o;
  logic [2:0] cur_row_o, cur_col_o;
  logic [6:0] cnt_o;
  logic       inc_o, ss_o, q_idle, q_clear, q_enter, q_solve, q_done;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int          m_state, m_sweep, m_row, m_col, m_dim, m_wa, m_wd;
  bit          m_we, m_inc, m_ss;
  logic [63:0] m_marks;
  logic [3:0]  m_mem [64];
  logic [3:0]  obs_mem [64];

  always #5 clk = ~clk;

  matrix_entry_ctrl dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .ack_i(ack), .enter_i(enter),
    .jump_i(jump), .clear_i(clear), .dim_i(dim), .row_sel_i(row_sel), .col_sel_i(col_sel),
    .data_in_i(data_in), .solve_done_i(solve_done), .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o),
    .wr_data_o(wr_data_o), .cur_row_o(cur_row_o), .cur_col_o(cur_col_o),
    .entered_cnt_o(cnt_o), .incomplete_o(inc_o), .solve_start_o(ss_o),
    .q_idle_o(q_idle), .q_clear_o(q_clear), .q_enter_o(q_enter), .q_solve_o(q_solve),
    .q_done_o(q_done)
  );

  task automatic begin_clear();
    m_state = S_CLEAR; m_sweep = 0; m_we = 1; m_wa = 0; m_wd = 0;
    m_row = 0; m_col = 0; m_marks = '0; m_inc = 0;
  endtask

  task automatic model_update();
    int n, idx;
    m_we = 0; m_ss = 0;
    if (reset) begin
      m_state = S_IDLE; m_row = 0; m_col = 0; m_dim = 7; m_marks = '0; m_inc = 0;
      return;
    end
    n = m_dim + 1;
    case (m_state)
      S_IDLE:  if (start) begin m_dim = int'(dim); begin_clear(); end
      S_CLEAR: begin
        if (m_sweep == 63) m_state = S_ENTER;
        else begin m_sweep++; m_we = 1; m_wa = m_sweep; m_wd = 0; end
      end
      S_ENTER: begin
        if (clear) begin_clear();
        else if (start) begin
          if ($countones(m_marks) == n * n) begin m_state = S_SOLVE; m_ss = 1; m_inc = 0; end
          else m_inc = 1;
        end else if (enter) begin
          m_we = 1; m_wa = m_row * 8 + m_col; m_wd = int'(data_in);
          m_marks[m_wa] = 1'b1; m_inc = 0;
          idx = (m_row * n + m_col + 1) % (n * n);
          m_row = idx / n; m_col = idx % n;
        end else if (jump && int'(row_sel) <= m_dim && int'(col_sel) <= m_dim) begin
          m_row = int'(row_sel); m_col = int'(col_sel);
        end
      end
      S_SOLVE: if (solve_done) m_state = S_DONE;
      default: if (ack) m_state = S_IDLE;
    endcase
    if (m_we) m_mem[m_wa] = 4'(m_wd);
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
    if (wr_en_o) obs_mem[wr_addr_o] = wr_data_o;
    reset = 0; start = 0; ack = 0; enter = 0; jump = 0; clear = 0; solve_done = 0;
  endtask

  task automatic wait_enter(input string tag);
    int n = 0;
    while (!q_enter && n < 100) begin tick(); n++; end
    checks++;
    if (!q_enter) begin errors++; $display("FAIL %s_timeout q_enter=%0b required 1", tag, q_enter); end
  endtask

  task automatic test_reset();
    reset = 1; tick(); reset = 1; tick();
    checks++;
    if ({q_idle, q_clear, q_enter, q_solve, q_done} !== 5'b10000) begin
      errors++; $display("FAIL reset_state got %b required 10000", {q_idle, q_clear, q_enter, q_solve, q_done});
    end
    checks++;
    if ({wr_en_o, wr_addr_o, wr_data_o, cur_row_o, cur_col_o, cnt_o, inc_o, ss_o} !== '0) begin
      errors++; $display("FAIL reset_outputs wr_en=%0b addr=%0d cnt=%0d inc=%0b ss=%0b required all 0",
                         wr_en_o, wr_addr_o, cnt_o, inc_o, ss_o);
    end
    $display("test_reset done");
  endtask

  task automatic test_clear_sweep();
    int bad = 0;
    start = 1; dim = 1; tick();
    for (int i = 0; i < 64; i++) begin
      checks++;
      if (wr_en_o !== 1'b1 || wr_addr_o !== 6'(i) || wr_data_o !== 4'd0) begin
        errors++; bad++;
        $display("FAIL clear_write[%0d] got en=%0b addr=%0d data=%0d required en=1 addr=%0d data=0",
                 i, wr_en_o, wr_addr_o, wr_data_o, i);
      end
      tick();
    end
    checks++;
    if (wr_en_o !== 1'b0 || q_enter !== 1'b1 || cur_row_o !== 3'd0 || cur_col_o !== 3'd0) begin
      errors++; $display("FAIL clear_end got en=%0b q_enter=%0b cur=(%0d,%0d) required en=0 q_enter=1 cur=(0,0)",
                         wr_en_o, q_enter, cur_row_o, cur_col_o);
    end
    $display("test_clear_sweep done, mismatching writes %0d", bad);
  endtask

  task automatic test_entry_dim1();
    logic [3:0] vals [4] = '{4'd5, 4'd3, 4'd9, 4'd2};
    logic [5:0] adrs [4] = '{6'd0, 6'd1, 6'd8, 6'd9};
    for (int i = 0; i < 4; i++) begin
      enter = 1; data_in = vals[i]; tick();
      checks++;
      if (wr_en_o !== 1'b1 || wr_addr_o !== adrs[i] || wr_data_o !== vals[i]) begin
        errors++; $display("FAIL entry_write[%0d] got en=%0b addr=%0d data=%0d required en=1 addr=%0d data=%0d",
                           i, wr_en_o, wr_addr_o, wr_data_o, adrs[i], vals[i]);
      end
      $display("entry %0d: addr=%0d data=%0d", i, wr_addr_o, wr_data_o);
    end
    checks++;
    if (cur_row_o !== 3'd0 || cur_col_o !== 3'd0 || cnt_o !== 7'd4) begin
      errors++; $display("FAIL entry_wrap got cur=(%0d,%0d) cnt=%0d required cur=(0,0) cnt=4",
                         cur_row_o, cur_col_o, cnt_o);
    end
  endtask

  task automatic test_incomplete_solve();
    reset = 1; tick();
    start = 1; dim = 2; tick();
    wait_enter("incomplete");
    for (int i = 0; i < 8; i++) begin enter = 1; data_in = 4'(i + 1); tick(); end
    start = 1; tick();
    checks++;
    if (inc_o !== 1'b1 || q_enter !== 1'b1 || ss_o !== 1'b0 || cnt_o !== 7'd8) begin
      errors++; $display("FAIL start_rejected got inc=%0b q_enter=%0b ss=%0b cnt=%0d required 1 1 0 8",
                         inc_o, q_enter, ss_o, cnt_o);
    end
    enter = 1; data_in = 4'd9; tick();
    checks++;
    if (inc_o !== 1'b0 || cnt_o !== 7'd9 || wr_addr_o !== 6'd18) begin
      errors++; $display("FAIL ninth_entry got inc=%0b cnt=%0d addr=%0d required 0 9 18", inc_o, cnt_o, wr_addr_o);
    end
    start = 1; tick();
    checks++;
    if (ss_o !== 1'b1 || q_solve !== 1'b1) begin
      errors++; $display("FAIL solve_start got ss=%0b q_solve=%0b required 1 1", ss_o, q_solve);
    end
    enter = 1; clear = 1; tick();
    checks++;
    if (ss_o !== 1'b0 || q_solve !== 1'b1 || wr_en_o !== 1'b0) begin
      errors++; $display("FAIL solve_hold got ss=%0b q_solve=%0b wr_en=%0b required 0 1 0", ss_o, q_solve, wr_en_o);
    end
    solve_done = 1; tick();
    checks++;
    if (q_done !== 1'b1) begin errors++; $display("FAIL solve_done got q_done=%0b required 1", q_done); end
    start = 1; tick();
    checks++;
    if (q_done !== 1'b1) begin errors++; $display("FAIL done_hold got q_done=%0b required 1", q_done); end
    ack = 1; tick();
    checks++;
    if (q_idle !== 1'b1) begin errors++; $display("FAIL ack_idle got q_idle=%0b required 1", q_idle); end
    $display("test_incomplete_solve done");
  endtask

  task automatic test_enter_jump();
    start = 1; dim = 2; tick();
    wait_enter("enter_jump");
    enter = 1; jump = 1; row_sel = 2; col_sel = 1; data_in = 4'd6; tick();
    checks++;
    if (wr_addr_o !== 6'd0 || wr_data_o !== 4'd6 || cur_row_o !== 3'd0 || cur_col_o !== 3'd1) begin
      errors++; $display("FAIL enter_jump got addr=%0d data=%0d cur=(%0d,%0d) required addr=0 data=6 cur=(0,1)",
                         wr_addr_o, wr_data_o, cur_row_o, cur_col_o);
    end
    jump = 1; row_sel = 5; col_sel = 5; tick();
    checks++;
    if (cur_row_o !== 3'd0 || cur_col_o !== 3'd1) begin
      errors++; $display("FAIL jump_out_of_range got cur=(%0d,%0d) required (0,1)", cur_row_o, cur_col_o);
    end
    jump = 1; row_sel = 2; col_sel = 2; tick();
    checks++;
    if (cur_row_o !== 3'd2 || cur_col_o !== 3'd2) begin
      errors++; $display("FAIL jump_edge got cur=(%0d,%0d) required (2,2)", cur_row_o, cur_col_o);
    end
    $display("test_enter_jump done");
  endtask

  task automatic test_reenter();
    jump = 1; row_sel = 1; col_sel = 1; tick();
    enter = 1; data_in = 4'd7; tick();
    checks++;
    if (cnt_o !== 7'd2 || wr_addr_o !== 6'd9 || wr_data_o !== 4'd7) begin
      errors++; $display("FAIL reenter_first got cnt=%0d addr=%0d data=%0d required 2 9 7", cnt_o, wr_addr_o, wr_data_o);
    end
    jump = 1; row_sel = 1; col_sel = 1; tick();
    enter = 1; data_in = 4'd4; tick();
    checks++;
    if (cnt_o !== 7'd2 || wr_addr_o !== 6'd9 || wr_data_o !== 4'd4 || cur_col_o !== 3'd2) begin
      errors++; $display("FAIL reenter_second got cnt=%0d addr=%0d data=%0d col=%0d required 2 9 4 2",
                         cnt_o, wr_addr_o, wr_data_o, cur_col_o);
    end
    $display("test_reenter done");
  endtask

  task automatic test_reset_midclear();
    reset = 1; tick();
    start = 1; dim = 4; tick();
    for (int i = 0; i < 30; i++) tick();
    checks++;
    if (wr_addr_o !== 6'd30 || q_clear !== 1'b1) begin
      errors++; $display("FAIL midclear_addr got addr=%0d q_clear=%0b required 30 1", wr_addr_o, q_clear);
    end
    reset = 1; tick();
    checks++;
    if (q_idle !== 1'b1 || q_clear !== 1'b0 || wr_en_o !== 1'b0) begin
      errors++; $display("FAIL midclear_reset got q_idle=%0b q_clear=%0b wr_en=%0b required 1 0 0",
                         q_idle, q_clear, wr_en_o);
    end
    $display("test_reset_midclear done");
  endtask

  task automatic test_random();
    int r, solves = 0;
    logic [4:0] exp_oh;
    reset = 1; tick();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      r = $urandom_range(0, 99);
      data_in = 4'($urandom); row_sel = 3'($urandom_range(0, 3)); col_sel = 3'($urandom_range(0, 3));
      case (m_state)
        S_IDLE:  if (r < 40) begin start = 1; dim = (r < 35) ? 3'($urandom_range(0, 2)) : 3'($urandom); end
        S_ENTER: begin
          if (r < 2) clear = 1;
          else if (r < 10) start = 1;
          else if (r < 65) begin enter = 1; jump = (r % 4 == 0); end
          else if (r < 85) jump = 1;
        end
        S_SOLVE: solve_done = (r < 30);
        S_DONE:  ack = (r < 35);
        default: begin clear = (r < 20); enter = (r > 70); end
      endcase
      if ($urandom_range(0, 999) == 0) reset = 1;
      if (m_state == S_ENTER && start) solves++;
      tick();
      exp_oh = 5'b10000 >> m_state;
      checks++;
      if ({q_idle, q_clear, q_enter, q_solve, q_done} !== exp_oh) begin
        errors++; $display("FAIL rnd_state cyc=%0d got %b required %b", cyc,
                           {q_idle, q_clear, q_enter, q_solve, q_done}, exp_oh);
      end
      checks++;
      if (wr_en_o !== m_we || (m_we && (wr_addr_o !== 6'(m_wa) || wr_data_o !== 4'(m_wd)))) begin
        errors++; $display("FAIL rnd_write cyc=%0d got en=%0b addr=%0d data=%0d required en=%0b addr=%0d data=%0d",
                           cyc, wr_en_o, wr_addr_o, wr_data_o, m_we, m_wa, m_wd);
      end
      checks++;
      if (cur_row_o !== 3'(m_row) || cur_col_o !== 3'(m_col) || cnt_o !== 7'($countones(m_marks))) begin
        errors++; $display("FAIL rnd_cursor cyc=%0d got cur=(%0d,%0d) cnt=%0d required (%0d,%0d) cnt=%0d",
                           cyc, cur_row_o, cur_col_o, cnt_o, m_row, m_col, $countones(m_marks));
      end
      checks++;
      if (inc_o !== m_inc || ss_o !== m_ss) begin
        errors++; $display("FAIL rnd_flags cyc=%0d got inc=%0b ss=%0b required inc=%0b ss=%0b",
                           cyc, inc_o, ss_o, m_inc, m_ss);
      end
    end
    for (int a = 0; a < 64; a++) begin
      checks++;
      if (obs_mem[a] !== m_mem[a]) begin
        errors++; $display("FAIL rnd_store addr=%0d got %0d required %0d", a, obs_mem[a], m_mem[a]);
      end
    end
    $display("test_random done, start requests in ENTER %0d", solves);
  endtask

  initial begin
    for (int a = 0; a < 64; a++) begin m_mem[a] = '0; obs_mem[a] = '0; end
    m_state = S_IDLE; m_row = 0; m_col = 0; m_dim = 7; m_marks = '0; m_sweep = 0;
    m_wa = 0; m_wd = 0; m_we = 0; m_inc = 0; m_ss = 0;
    test_reset();
    test_clear_sweep();
    test_entry_dim1();
    test_incomplete_solve();
    test_enter_jump();
    test_reenter();
    test_reset_midclear();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
